// File: rtl/syn_read.sv
// syn_read: streams one weight row per cycle from banked BRAM, masks the
// 24 lanes with the latched pre-synaptic spikes and accumulates a 26-bit
// current for each post-synaptic neuron.
// Ports: clk, reset (sync, active-high); i_run start pulse; i_pre_spike
// spike vector; o_busy / o_done status; o_syn_current packed 26-bit sums;
// addr_r / ce_r / we_r / d_r / q_r BRAM read port (1-cycle latency).
// Build option: define SYN_ROW_SKIP_EN to gate ce_r off for rows whose
// latched spike slice is all zero.
module syn_read #(
    parameter int N_POST = 18,
    parameter int N_ROW  = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run,
    input  logic [24*N_ROW-1:0]    i_pre_spike,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [26*N_POST-1:0]   o_syn_current,
    output logic [53:0]            addr_r,
    output logic [5:0]             ce_r,
    output logic [5:0]             we_r,
    output logic [383:0]           d_r,
    input  logic [383:0]           q_r
);

    localparam int NL     = 24;
    localparam int N_ADDR = N_POST * N_ROW;
    localparam int NW     = $clog2(N_POST);
    localparam int RW     = $clog2(N_ROW);
    localparam logic [8:0]    A_LAST = 9'(N_ADDR - 1);
    localparam logic [RW-1:0] R_LAST = RW'(N_ROW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [8:0]         addr;
    logic [NW-1:0]      n_idx;
    logic [RW-1:0]      r_idx;
    logic               drain_cnt;
    logic [NL*N_ROW-1:0] spk;

    // Stage 1: aligned with q_r; stage 2: registered lane sum.
    logic               v1;
    logic [NW-1:0]      n1;
    logic [NL-1:0]      m1;
    logic               v2;
    logic [NW-1:0]      n2;
    logic [20:0]        lsum;
    logic [20:0]        lane_sum_c;

    logic [25:0]        acc [N_POST];

    logic               start;
    logic               issue;
    logic               row_en;
    logic [NL-1:0]      slice;

    assign start = (state == S_IDLE) && i_run;
    assign issue = (state == S_RUN);
    assign slice = spk[int'(r_idx)*NL +: NL];

`ifdef SYN_ROW_SKIP_EN
    assign row_en = issue && (|slice);
`else
    assign row_en = issue;
`endif

    assign o_busy = (state == S_RUN) || (state == S_DRAIN);
    assign o_done = (state == S_DONE);
    assign addr_r = {6{addr}};
    assign ce_r   = {6{row_en}};
    assign we_r   = '0;
    assign d_r    = '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (i_run) state_nx = S_RUN;
            S_RUN:   if (addr == A_LAST) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        lane_sum_c = '0;
        for (int l = 0; l < NL; l++) begin
            if (m1[l]) lane_sum_c = lane_sum_c + 21'(q_r[16*l +: 16]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            n_idx     <= '0;
            r_idx     <= '0;
            drain_cnt <= 1'b0;
            spk       <= '0;
            v1        <= 1'b0;
            n1        <= '0;
            m1        <= '0;
            v2        <= 1'b0;
            n2        <= '0;
            lsum      <= '0;
            for (int k = 0; k < N_POST; k++) acc[k] <= '0;
        end else begin
            state <= state_nx;

            if (start) begin
                spk       <= i_pre_spike;
                addr      <= '0;
                n_idx     <= '0;
                r_idx     <= '0;
                drain_cnt <= 1'b0;
            end else if (issue) begin
                if (addr != A_LAST) addr <= addr + 9'd1;
                if (r_idx == R_LAST) begin
                    r_idx <= '0;
                    n_idx <= n_idx + NW'(1);
                end else begin
                    r_idx <= r_idx + RW'(1);
                end
            end else if (state == S_DRAIN) begin
                drain_cnt <= 1'b1;
            end

            // Neuron index travels with the data so row sums land in
            // the right accumulator across neuron boundaries.
            v1   <= issue;
            n1   <= n_idx;
            m1   <= row_en ? slice : '0;
            v2   <= v1;
            n2   <= n1;
            lsum <= lane_sum_c;

            for (int k = 0; k < N_POST; k++) begin
                if (start)
                    acc[k] <= '0;
                else if (v2 && n2 == NW'(k))
                    acc[k] <= acc[k] + 26'(lsum);
            end
        end
    end

    always_comb begin
        o_syn_current = '0;
        for (int k = 0; k < N_POST; k++) o_syn_current[26*k +: 26] = acc[k];
    end

endmodule

// File: doc/syn_read.md
SYN_READ -- requirements
Module: syn_read

Interface
REQ-001 SHALL have parameter N_POST, default 18, number of post-synaptic neurons.
REQ-002 SHALL have parameter N_ROW, default 24, weight rows per post neuron; each row holds 24 16-bit weights in lanes 0..23.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port i_run  input  1  start pulse, sampled only in IDLE.
REQ-006 SHALL have port i_pre_spike  input  576  pre-synaptic spike vector; bit r*24+l maps to lane l of row r.
REQ-007 SHALL have port o_busy  output  1  high in RUN and DRAIN.
REQ-008 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port o_syn_current  output  468  18 x 26-bit unsigned currents; neuron n occupies bits [26n +: 26].
REQ-010 SHALL have BRAM read ports: addr_r output 54 (6 banks x 9 bits, all equal); ce_r output 6; we_r output 6 (tied 0); d_r output 384 (tied 0); q_r input 384, 1-cycle read latency, lane l = q_r[16l +: 16].

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN, DONE: IDLE->RUN on i_run; RUN->DRAIN after address 431 is issued; DRAIN lasts exactly 2 cycles, then DONE; DONE->IDLE unconditionally.
REQ-012 SHALL latch i_pre_spike on the i_run sample edge; later input changes SHALL NOT affect the run.
REQ-013 SHALL clear all 18 accumulators on the i_run sample edge.
REQ-014 SHALL issue address a = n*24 + r, increasing by 1 per RUN cycle from 0 to 431: neuron n = 0..17, row r = 0..23.
REQ-015 SHALL, one cycle after issue, AND each q_r lane l with latched spike bit r*24+l and sum the 24 masked lanes into a 21-bit registered lane sum.
REQ-016 SHALL, one cycle after the lane-sum register loads, add the lane sum to accumulator n (26 bits, no overflow possible: max 576*65535 = 0x23FFDC0).
REQ-017 SHALL carry neuron index n down the pipeline with the data so that accumulation is correct across neuron boundaries.
REQ-018 SHALL assert o_done for exactly 1 cycle, 435 cycles after the i_run sample edge (DONE state).
REQ-019 SHALL ignore i_run while not in IDLE, including in DONE.
REQ-020 SHALL drive o_syn_current from the accumulators; the value is valid from o_done and is held until the next i_run.
REQ-021 SHALL assert ce_r only in RUN, subject to REQ-025.

Reset
REQ-022 SHALL, on reset, force IDLE, zero all accumulators, the pipeline registers and addresses, and drive o_done=0, o_busy=0, ce_r=0, o_syn_current=0.
REQ-023 SHALL, on reset asserted mid-run, abort that run with no o_done pulse; the next i_run after reset release SHALL start a full clean run.

Configuration
REQ-024 SHALL support macro SYN_ROW_SKIP_EN.
REQ-025 SHALL, with SYN_ROW_SKIP_EN defined, deassert ce_r for every issued row whose 24-bit latched spike slice is zero, and SHALL force that row's lane sum to 0. Address sequencing and latency SHALL be unchanged.
REQ-026 SHALL, without SYN_ROW_SKIP_EN, assert ce_r for all 432 RUN cycles.

Verification
REQ-027 SHALL cover: all spikes 0, any memory contents -> all currents 0; o_done exactly 435 cycles after i_run; 432 ce_r cycles.
REQ-028 SHALL cover: only spike bit 0 set; lane 0 of every row = 0x0100 -> each of the 18 currents = 0x100.
REQ-029 SHALL cover: all spikes 1; all weights 0xFFFF -> each current = 0x23FFDC0.
REQ-030 SHALL cover: lane l of row r of neuron n = n+1; only spike bits 5 and 100 set -> current n = 2*(n+1).
REQ-031 SHALL cover: i_run re-pulsed at cycle 50 -> ignored; single o_done at cycle 435; reset at cycle 100 -> no o_done and outputs 0.
REQ-032 SHALL cover: SYN_ROW_SKIP_EN with only row-3 slice nonzero -> 18 ce_r cycles; currents identical to the non-skip build; o_done at cycle 435.
